framebuffer_scanout: RTL and testbench
======================================

FRAMEBUFFER_SCANOUT -- requirements
Module: framebuffer_scanout

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- FRAME_WIDTH, 4, stored pixels per row.
- FRAME_HEIGHT, 3, stored rows.
- SCALING_FACTOR, 1, output repeats per pixel and per row; must be 1 or more.
- ADDR_WIDTH, 4, framebuffer address width; must hold FRAME_WIDTH*FRAME_HEIGHT-1.
- DATA_WIDTH, 8, pixel width.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_rd, in, 1, single clock, rising edge.
- rst_req_n, in, 1, asynchronous active-low reset.
- enable, in, 1, scanout request, sampled at frame boundaries.
- rst_busy, in, 1, framebuffer clear in progress.
- en_rd, out, 1, framebuffer read strobe.
- addr_rd, out, ADDR_WIDTH, framebuffer read address.
- dout, in, DATA_WIDTH, framebuffer read data, valid 1 cycle after en_rd.
- pix_valid, out, 1, output pixel valid.
- pix_ready, in, 1, sink accepts the pixel.
- pix_data, out, DATA_WIDTH, output pixel.
- pix_sof, out, 1, first pixel of frame.
- pix_eol, out, 1, last pixel of output line.
- frame_cnt, out, 16, completed-frame count (see REQ-019).

Function
REQ-003 Output frame SHALL be (FRAME_WIDTH*SCALING_FACTOR) x (FRAME_HEIGHT*SCALING_FACTOR) pixels, raster order.
REQ-004 For output column x and output row y, addr_rd SHALL be (y/SCALING_FACTOR)*FRAME_WIDTH + x/SCALING_FACTOR, computed by sub-counters only, with no divider.
REQ-005 One framebuffer read SHALL be issued per output pixel, including repeated pixels.
REQ-006 The FSM SHALL have states IDLE and RUN; IDLE->RUN when enable=1 and rst_busy=0; RUN->IDLE after the last read of a frame only if enable=0; otherwise the next frame's first read SHALL follow with no gap.
REQ-007 enable=0 mid-frame SHALL NOT truncate the frame; the frame completes.
REQ-008 rst_busy=1 in RUN SHALL stall read issue with counters held; issue resumes the cycle after rst_busy=0.
REQ-009 Output SHALL use a 2-entry buffer; en_rd SHALL assert only when occupancy + reads in flight - pop this cycle < 2.
REQ-010 Data SHALL be captured into the buffer on the cycle after en_rd, and pix_valid SHALL rise 2 cycles after the first en_rd.
REQ-011 Handshake: a transfer occurs when pix_valid=1 and pix_ready=1; pix_data, pix_sof and pix_eol SHALL be stable while pix_valid=1 and pix_ready=0.
REQ-012 With pix_ready held at 1, throughput SHALL be 1 pixel per cycle, and no pixel SHALL be dropped or duplicated under any pix_ready pattern.
REQ-013 pix_sof SHALL accompany output pixel (0,0); pix_eol SHALL accompany x=FRAME_WIDTH*SCALING_FACTOR-1 on every output row.
REQ-014 Counters SHALL wrap x to 0 and increment y at end of line, and wrap y to 0 at end of frame.
REQ-015 Buffered pixels SHALL drain after the FSM enters IDLE.

Reset
REQ-016 While rst_req_n=0, en_rd, addr_rd, pix_valid, pix_data, pix_sof, pix_eol and frame_cnt SHALL be 0, the FSM SHALL be IDLE, and counters and buffer SHALL be empty.
REQ-017 Reset mid-frame SHALL discard in-flight and buffered data, and the next frame SHALL start at address 0 with pix_sof.
REQ-018 Reset release SHALL take effect on the first rising edge of clk_rd with rst_req_n=1.

Configuration
REQ-019 With FRAMEBUFFER_SCANOUT_FRAME_CNT_EN defined, frame_cnt SHALL increment, wrapping at 16 bits, on each accepted pix_eol of the last output row; when undefined, frame_cnt SHALL be tied to 0.

Verification
REQ-020 W=4, H=3, SF=1, memory[i]=i, enable=1, pix_ready=1 -> pix_data 0..11 on consecutive cycles, pix_sof with 0, pix_eol with 3, 7 and 11.
REQ-021 Same setup, SF=2 -> 8x6 frame; row 0 is 0,0,1,1,2,2,3,3 and row 1 repeats row 0; row 2 starts 4,4.
REQ-022 pix_ready toggling 1,0,0,1 repeating -> the sequence is identical to REQ-020 with no loss or duplication, and data is stable during stalls.
REQ-023 rst_busy=1 for 5 cycles after pixel 5 is issued -> en_rd low for those 5 cycles, then the output resumes at 6.
REQ-024 enable dropped after pixel 2 -> pixels continue through 11, then IDLE with en_rd=0; with the macro defined, frame_cnt=1.
REQ-025 rst_req_n=0 for 1 cycle after pixel 7 -> all outputs 0; enable=1 then restarts at 0 with pix_sof, and frame_cnt=0.

Source files
------------

// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout
//   Reads a FRAME_WIDTH x FRAME_HEIGHT framebuffer in raster order and emits
//   it as a valid/ready pixel stream, replicating every pixel and every row
//   SCALING_FACTOR times. One framebuffer read is issued per output pixel.
//   Read data returns one cycle after en_rd and lands in a 2-entry output
//   buffer. Reads are issued only while the reads still owed to that buffer
//   fit in it.
//
//   Optional feature: define FRAMEBUFFER_SCANOUT_FRAME_CNT_EN to count
//   completed frames on frame_cnt. Without it, frame_cnt is tied to 0.
//
//   Ports
//     clk_rd     in   1           clock, rising edge
//     rst_req_n  in   1           asynchronous active-low reset
//     enable     in   1           scanout request, sampled at frame boundaries
//     rst_busy   in   1           framebuffer clear in progress (stalls reads)
//     en_rd      out  1           framebuffer read strobe
//     addr_rd    out  ADDR_WIDTH  framebuffer read address
//     dout       in   DATA_WIDTH  framebuffer read data, one cycle after en_rd
//     pix_valid  out  1           output pixel valid
//     pix_ready  in   1           sink accepts the pixel
//     pix_data   out  DATA_WIDTH  output pixel
//     pix_sof    out  1           first pixel of frame
//     pix_eol    out  1           last pixel of output line
//     frame_cnt  out  16          completed-frame count
module framebuffer_scanout #(
  parameter int FRAME_WIDTH    = 4,
  parameter int FRAME_HEIGHT   = 3,
  parameter int SCALING_FACTOR = 1,
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                  clk_rd,
  input  logic                  rst_req_n,
  input  logic                  enable,
  input  logic                  rst_busy,
  output logic                  en_rd,
  output logic [ADDR_WIDTH-1:0] addr_rd,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_sof,
  output logic                  pix_eol,
  output logic [15:0]           frame_cnt
);

  localparam int SW = (SCALING_FACTOR > 1) ? $clog2(SCALING_FACTOR) : 1;
  localparam int CW = (FRAME_WIDTH > 1)    ? $clog2(FRAME_WIDTH)    : 1;
  localparam int RW = (FRAME_HEIGHT > 1)   ? $clog2(FRAME_HEIGHT)   : 1;
  localparam logic [SW-1:0]         SUB_LAST = SW'(SCALING_FACTOR - 1);
  localparam logic [CW-1:0]         COL_LAST = CW'(FRAME_WIDTH - 1);
  localparam logic [RW-1:0]         ROW_LAST = RW'(FRAME_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(FRAME_WIDTH);
`ifdef FRAMEBUFFER_SCANOUT_FRAME_CNT_EN
  localparam int MW = 3;  // {eof, eol, sof}
`else
  localparam int MW = 2;  // {eol, sof}
`endif

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state;
  logic [SW-1:0]         x_sub_p0, y_sub_p0;
  logic [CW-1:0]         col_p0;
  logic [RW-1:0]         row_p0;
  logic [ADDR_WIDTH-1:0] addr_p0, row_base_p0;
  logic                  line_end, frame_end, sof_p0;
  logic [MW-1:0]         meta_p0, meta_p1;
  logic                  vld_p1;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] hd_data, tl_data;
  logic [MW-1:0]         hd_meta, tl_meta;
  logic                  pop, credit_ok;

  assign line_end  = (x_sub_p0 == SUB_LAST) && (col_p0 == COL_LAST);
  assign frame_end = line_end && (y_sub_p0 == SUB_LAST) && (row_p0 == ROW_LAST);
  assign sof_p0    = (x_sub_p0 == '0) && (col_p0 == '0) && (y_sub_p0 == '0) && (row_p0 == '0);
`ifdef FRAMEBUFFER_SCANOUT_FRAME_CNT_EN
  assign meta_p0 = {frame_end, line_end, sof_p0};
`else
  assign meta_p0 = {line_end, sof_p0};
`endif

  // Reads owed to the buffer (buffered + in flight), less the pixel leaving
  // this cycle, must stay below its depth of 2.
  assign pop       = pix_valid && pix_ready;
  assign credit_ok = ({1'b0, occ} + {2'b0, vld_p1}) < (3'd2 + {2'b0, pop});
  assign en_rd     = (state == RUN) && !rst_busy && credit_ok;
  assign addr_rd   = addr_p0;

  // ---- p0: FSM and raster counters; address tracked incrementally ----
  always_ff @(posedge clk_rd or negedge rst_req_n) begin
    if (!rst_req_n) begin
      state       <= IDLE;
      x_sub_p0    <= '0;
      y_sub_p0    <= '0;
      col_p0      <= '0;
      row_p0      <= '0;
      addr_p0     <= '0;
      row_base_p0 <= '0;
    end else begin
      case (state)
        IDLE: if (enable && !rst_busy) state <= RUN;
        RUN: if (en_rd) begin
          if (frame_end && !enable) state <= IDLE;
          if (x_sub_p0 != SUB_LAST) begin
            x_sub_p0 <= x_sub_p0 + SW'(1);
          end else begin
            x_sub_p0 <= '0;
            if (col_p0 != COL_LAST) begin
              col_p0  <= col_p0 + CW'(1);
              addr_p0 <= addr_p0 + ADDR_WIDTH'(1);
            end else begin
              col_p0 <= '0;
              if (y_sub_p0 != SUB_LAST) begin
                // Repeat the same stored row: rewind to its base address.
                y_sub_p0 <= y_sub_p0 + SW'(1);
                addr_p0  <= row_base_p0;
              end else begin
                y_sub_p0 <= '0;
                if (row_p0 != ROW_LAST) begin
                  row_p0      <= row_p0 + RW'(1);
                  row_base_p0 <= row_base_p0 + ROW_STEP;
                  addr_p0     <= row_base_p0 + ROW_STEP;
                end else begin
                  row_p0      <= '0;
                  row_base_p0 <= '0;
                  addr_p0     <= '0;
                end
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- p1: read in flight; markers travel beside the returning data ----
  always_ff @(posedge clk_rd) begin
    if (en_rd) meta_p1 <= meta_p0;
  end

  // ---- p2: 2-entry output buffer, head entry drives the pixel outputs ----
  always_ff @(posedge clk_rd or negedge rst_req_n) begin
    if (!rst_req_n) begin
      vld_p1  <= 1'b0;
      occ     <= '0;
      hd_data <= '0;
      hd_meta <= '0;
    end else begin
      vld_p1 <= en_rd;
      occ    <= occ + {1'b0, vld_p1} - {1'b0, pop};
      if (pop && (occ == 2'd2)) begin
        hd_data <= tl_data;
        hd_meta <= tl_meta;
      end else if (vld_p1 && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
        hd_data <= dout;
        hd_meta <= meta_p1;
      end
    end
  end

  always_ff @(posedge clk_rd) begin
    if (vld_p1 && (((occ == 2'd1) && !pop) || ((occ == 2'd2) && pop))) begin
      tl_data <= dout;
      tl_meta <= meta_p1;
    end
  end

  assign pix_valid = (occ != 2'd0);
  assign pix_data  = hd_data;
  assign pix_sof   = hd_meta[0];
  assign pix_eol   = hd_meta[1];

`ifdef FRAMEBUFFER_SCANOUT_FRAME_CNT_EN
  always_ff @(posedge clk_rd or negedge rst_req_n) begin
    if (!rst_req_n)             frame_cnt <= '0;
    else if (pop && hd_meta[2]) frame_cnt <= frame_cnt + 16'd1;
  end
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Bench for framebuffer_scanout: one instance at scale 1 and one at scale 2,
// each reading a memory holding mem[i] = i.
module tb_framebuffer_scanout;
  localparam int W = 4;
  localparam int H = 3;
`ifdef FRAMEBUFFER_SCANOUT_FRAME_CNT_EN
  localparam int FC_EN = 1;
`else
  localparam int FC_EN = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rn_a, en_a, busy_a, rdy_a, en_rd_a, pv_a, sof_a, eol_a;
  logic [3:0] addr_a;
  logic [7:0] dout_a, pd_a;
  logic [15:0] fc_a;
  logic       rn_b, en_b, busy_b, rdy_b, en_rd_b, pv_b, sof_b, eol_b;
  logic [3:0] addr_b;
  logic [7:0] dout_b, pd_b;
  logic [15:0] fc_b;

  framebuffer_scanout #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .SCALING_FACTOR(1),
                        .ADDR_WIDTH(4), .DATA_WIDTH(8)) dut_a (
    .clk_rd(clk), .rst_req_n(rn_a), .enable(en_a), .rst_busy(busy_a),
    .en_rd(en_rd_a), .addr_rd(addr_a), .dout(dout_a), .pix_valid(pv_a),
    .pix_ready(rdy_a), .pix_data(pd_a), .pix_sof(sof_a), .pix_eol(eol_a),
    .frame_cnt(fc_a));

  framebuffer_scanout #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .SCALING_FACTOR(2),
                        .ADDR_WIDTH(4), .DATA_WIDTH(8)) dut_b (
    .clk_rd(clk), .rst_req_n(rn_b), .enable(en_b), .rst_busy(busy_b),
    .en_rd(en_rd_b), .addr_rd(addr_b), .dout(dout_b), .pix_valid(pv_b),
    .pix_ready(rdy_b), .pix_data(pd_b), .pix_sof(sof_b), .pix_eol(eol_b),
    .frame_cnt(fc_b));

  logic [7:0] mem [0:15];
  always @(posedge clk) if (en_rd_a) dout_a <= mem[addr_a];
  always @(posedge clk) if (en_rd_b) dout_b <= mem[addr_b];

  int checks = 0, errors = 0;
  int cyc_n[2], pos[2], rpos[2], outst[2], fexp[2], first_en[2], first_v[2];
  bit held[2];
  logic [7:0] hd[2];
  logic hs[2], he[2];
  int logd[2][256], logc[2][256];
  bit logs[2][256], loge[2][256];
  int logn[2];
  bit s_en[2], s_pv[2];
  int s_addr[2], s_fc[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Framebuffer address feeding output pixel p of a frame scaled by sf.
  function automatic int exp_addr(input int sf, input int p);
    int ow = W * sf;
    return ((p / ow) / sf) * W + (p % ow) / sf;
  endfunction

  task automatic model(input int k, input logic rn, e, input logic [3:0] a,
                       input logic v, r, input logic [7:0] d, input logic so, eo,
                       input logic [15:0] fc, input logic bz);
    int sf = k + 1;
    int ow = W * sf;
    int fp = W * H * sf * sf;
    bit pop;
    cyc_n[k]++;
    s_en[k] = e; s_addr[k] = a; s_pv[k] = v; s_fc[k] = fc;
    if (!rn) begin
      chk("rst_en_rd", e, 0);  chk("rst_addr", a, 0);  chk("rst_valid", v, 0);
      chk("rst_data", d, 0);   chk("rst_sof", so, 0);  chk("rst_eol", eo, 0);
      chk("rst_frame_cnt", fc, 0);
      pos[k] = 0; rpos[k] = 0; outst[k] = 0; fexp[k] = 0; held[k] = 0;
      return;
    end
    pop = v && r;
    chk("frame_cnt", fc, fexp[k]);
    if (bz) chk("busy_en_rd", e, 0);
    if (held[k]) begin
      chk("stall_valid", v, 1); chk("stall_data", d, hd[k]);
      chk("stall_sof", so, hs[k]); chk("stall_eol", eo, he[k]);
    end
    if (e) begin
      chk("rd_credit", (outst[k] - int'(pop)) < 2, 1);
      chk("rd_addr", a, exp_addr(sf, rpos[k]));
      rpos[k] = (rpos[k] + 1) % fp;
      outst[k]++;
      if (first_en[k] < 0) first_en[k] = cyc_n[k];
    end
    if (v && first_v[k] < 0) first_v[k] = cyc_n[k];
    if (pop) begin
      chk("pix_data", d, mem[exp_addr(sf, pos[k])]);
      chk("pix_sof", so, pos[k] == 0);
      chk("pix_eol", eo, (pos[k] % ow) == ow - 1);
      if (logn[k] < 256) begin
        logd[k][logn[k]] = d; logs[k][logn[k]] = so;
        loge[k][logn[k]] = eo; logc[k][logn[k]] = cyc_n[k];
      end
      logn[k]++;
      if (FC_EN == 1 && pos[k] == fp - 1) fexp[k] = (fexp[k] + 1) % 65536;
      pos[k] = (pos[k] + 1) % fp;
      outst[k]--;
    end
    held[k] = v && !r; hd[k] = d; hs[k] = so; he[k] = eo;
  endtask

  // Inputs are set at the falling edge; outputs are sampled 1 ns later.
  task automatic cyc();
    #1;
    model(0, rn_a, en_rd_a, addr_a, pv_a, rdy_a, pd_a, sof_a, eol_a, fc_a, busy_a);
    model(1, rn_b, en_rd_b, addr_b, pv_b, rdy_b, pd_b, sof_b, eol_b, fc_b, busy_b);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int k, input int bound);
    int i = 0;
    while (i < bound && (s_pv[k] || s_en[k] || outst[k] != 0)) begin
      cyc(); i++;
    end
    chk("idle_reached", s_pv[k] || s_en[k] || outst[k] != 0, 0);
  endtask

  task automatic run_px(input int k, input int target, input int bound);
    int i = 0;
    while (i < bound && logn[k] < target) begin
      cyc(); i++;
    end
    chk("pixel_timeout", logn[k] >= target, 1);
  endtask

  initial begin
    int s, s2;
    int row0[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    for (int k = 0; k < 2; k++) begin
      cyc_n[k] = 0; pos[k] = 0; rpos[k] = 0; outst[k] = 0; fexp[k] = 0;
      first_en[k] = -1; first_v[k] = -1; held[k] = 0; logn[k] = 0;
      s_en[k] = 0; s_pv[k] = 0; s_addr[k] = 0; s_fc[k] = 0;
    end
    rn_a = 0; en_a = 0; busy_a = 0; rdy_a = 0;
    rn_b = 0; en_b = 0; busy_b = 0; rdy_b = 0;
    @(negedge clk);
    repeat (3) cyc();
    rn_a = 1; rn_b = 1;
    repeat (2) cyc();

    // Scale 2: 8x6 frame, enable pulsed for one cycle only.
    s = logn[1]; rdy_b = 1; en_b = 1;
    cyc();
    en_b = 0;
    run_px(1, s + 48, 200);
    wait_idle(1, 40);
    repeat (4) cyc();
    chk("b_count", logn[1] - s, 48);
    for (int j = 0; j < 8; j++) begin
      chk("b_row0", logd[1][s + j], row0[j]);
      chk("b_row1", logd[1][s + 8 + j], row0[j]);
    end
    chk("b_row2_0", logd[1][s + 16], 4);
    chk("b_row2_1", logd[1][s + 17], 4);
    chk("b_sof", logs[1][s], 1);
    chk("b_eol7", loge[1][s + 7], 1);
    chk("b_eol6", loge[1][s + 6], 0);
    chk("b_last", logd[1][s + 47], 11);
    chk("b_frame_cnt", s_fc[1], FC_EN);

    // Scale 1, enable held, ready held: 0..11 back to back.
    s = logn[0]; first_en[0] = -1; first_v[0] = -1; en_a = 1; rdy_a = 1;
    run_px(0, s + 12, 60);
    for (int j = 0; j < 12; j++) chk("a_seq", logd[0][s + j], j);
    chk("a_sof", logs[0][s], 1);
    chk("a_eol3", loge[0][s + 3], 1);
    chk("a_eol7", loge[0][s + 7], 1);
    chk("a_eol11", loge[0][s + 11], 1);
    chk("a_eol2", loge[0][s + 2], 0);
    chk("a_back_to_back", logc[0][s + 11] - logc[0][s], 11);
    chk("a_latency", first_v[0] - first_en[0], 2);
    en_a = 0;
    wait_idle(0, 60);
    chk("a_two_frames", logn[0] - s, 24);
    chk("a_frame_cnt2", s_fc[0], 2 * FC_EN);

    // Ready pattern 1,0,0,1.
    s = logn[0]; en_a = 1;
    for (int i = 0; i < 150 && logn[0] < s + 12; i++) begin
      rdy_a = (i % 4 == 0) || (i % 4 == 3);
      if (i == 1) en_a = 0;
      cyc();
    end
    rdy_a = 1;
    wait_idle(0, 20);
    chk("stall_count", logn[0] - s, 12);
    for (int j = 0; j < 12; j++) chk("stall_seq", logd[0][s + j], j);
    chk("stall_span", logc[0][s + 11] - logc[0][s] > 11, 1);

    // rst_busy for 5 cycles after pixel 5 is read.
    s = logn[0]; en_a = 1; rdy_a = 1;
    for (int i = 0; i < 40 && !(s_en[0] && s_addr[0] == 5); i++) cyc();
    chk("busy_setup", s_en[0] && s_addr[0] == 5, 1);
    busy_a = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("busy_hold", s_en[0], 0);
    end
    busy_a = 0;
    cyc();
    chk("busy_resume_en", s_en[0], 1);
    chk("busy_resume_addr", s_addr[0], 6);
    en_a = 0;
    run_px(0, s + 12, 40);
    wait_idle(0, 20);
    chk("busy_count", logn[0] - s, 12);
    for (int j = 0; j < 12; j++) chk("busy_seq", logd[0][s + j], j);

    // Fresh reset, enable dropped after pixel 2.
    rn_a = 0; cyc(); rn_a = 1;
    s = logn[0]; en_a = 1;
    run_px(0, s + 3, 20);
    en_a = 0;
    run_px(0, s + 12, 40);
    wait_idle(0, 20);
    repeat (5) cyc();
    chk("drop_count", logn[0] - s, 12);
    for (int j = 0; j < 12; j++) chk("drop_seq", logd[0][s + j], j);
    chk("drop_en_rd", s_en[0], 0);
    chk("drop_valid", s_pv[0], 0);
    chk("drop_frame_cnt", s_fc[0], FC_EN);

    // Reset for one cycle after pixel 7.
    s = logn[0]; en_a = 1;
    run_px(0, s + 8, 30);
    rn_a = 0;
    cyc();
    chk("midrst_en_rd", s_en[0], 0);
    chk("midrst_valid", s_pv[0], 0);
    chk("midrst_frame_cnt", s_fc[0], 0);
    rn_a = 1;
    s2 = logn[0];
    run_px(0, s2 + 1, 20);
    chk("restart_data", logd[0][s2], 0);
    chk("restart_sof", logs[0][s2], 1);
    chk("restart_frame_cnt", s_fc[0], 0);
    en_a = 0;
    wait_idle(0, 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
